// File: rtl/fetch_pkg.sv
// Shared constants for the ROM fetch stage: FSM state encoding, default vectors
// and the opcode-length decode helper.
package fetch_pkg;

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_OPC   = 2'd1;
  localparam logic [1:0] S_ARG   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [7:0] DEF_RESET_VECTOR = 8'h00;
  localparam logic [7:0] DEF_IRQ_VECTOR   = 8'hF0;
  localparam int         DEF_OPERAND_BIT  = 3;

  // True when the opcode announces a trailing operand byte.
  function automatic logic has_operand(input logic [7:0] opcode, input int bit_idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == bit_idx) begin
        r = opcode[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_fetch_unit.sv
// Instruction fetch stage behind a 1-cycle synchronous ROM; assembles 1/2-byte
// instructions for a valid/ready consumer. Optional interrupt redirect: FETCH_IRQ_EN.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter int                    OPERAND_BIT  = DEF_OPERAND_BIT
`ifdef FETCH_IRQ_EN
  , parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = ADDR_WIDTH'(DEF_IRQ_VECTOR)
`endif
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [7:0]            ROM_DATA,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [7:0]            OPCODE,
  output logic [7:0]            OPERAND,
  output logic                  HAS_OPERAND,
  output logic [ADDR_WIDTH-1:0] PC,
  input  logic                  JUMP_EN,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR
`ifdef FETCH_IRQ_EN
  , input  logic                  IRQ
  , output logic                  IRQ_ACK
  , output logic [ADDR_WIDTH-1:0] RET_PC
`endif
);

  localparam logic [ADDR_WIDTH-1:0] FP_ONE = ADDR_WIDTH'(1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_fp;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [7:0]            r_opcode;
  logic [7:0]            r_operand;
  logic                  r_has_op;
  logic                  r_valid;
  logic                  w_rom_has_op;
`ifdef FETCH_IRQ_EN
  logic                  r_irq_ack;
  logic [ADDR_WIDTH-1:0] r_ret_pc;
`endif

  assign w_rom_has_op = has_operand(ROM_DATA, OPERAND_BIT);

  assign ROM_ADDR    = r_fp;
  assign INSTR_VALID = r_valid;
  assign OPCODE      = r_opcode;
  assign OPERAND     = r_operand;
  assign HAS_OPERAND = r_has_op;
  assign PC          = r_pc;
`ifdef FETCH_IRQ_EN
  assign IRQ_ACK     = r_irq_ack;
  assign RET_PC      = r_ret_pc;
`endif

  // Fetch FSM: FP always points one byte ahead so ROM latency is hidden.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= S_ISSUE;
      r_fp      <= RESET_VECTOR;
      r_pc      <= '0;
      r_opcode  <= 8'h00;
      r_operand <= 8'h00;
      r_has_op  <= 1'b0;
      r_valid   <= 1'b0;
`ifdef FETCH_IRQ_EN
      r_irq_ack <= 1'b0;
      r_ret_pc  <= '0;
`endif
    end else begin
`ifdef FETCH_IRQ_EN
      r_irq_ack <= 1'b0;
`endif
      if (JUMP_EN) begin
        r_fp    <= JUMP_ADDR;
        r_valid <= 1'b0;
        r_state <= S_ISSUE;
      end else begin
        case (r_state)
          S_ISSUE: begin
            r_fp    <= r_fp + FP_ONE;
            r_state <= S_OPC;
          end
          S_OPC: begin
            r_opcode <= ROM_DATA;
            r_has_op <= w_rom_has_op;
            r_pc     <= r_fp - FP_ONE;
            if (w_rom_has_op) begin
              r_fp    <= r_fp + FP_ONE;
              r_state <= S_ARG;
            end else begin
              r_operand <= 8'h00;
              r_valid   <= 1'b1;
              r_state   <= S_HOLD;
            end
          end
          S_ARG: begin
            r_operand <= ROM_DATA;
            r_valid   <= 1'b1;
            r_state   <= S_HOLD;
          end
          S_HOLD: begin
            if (INSTR_READY) begin
              r_valid <= 1'b0;
`ifdef FETCH_IRQ_EN
              // Instruction boundary: FP already holds the return address.
              if (IRQ) begin
                r_ret_pc  <= r_fp;
                r_fp      <= IRQ_VECTOR;
                r_irq_ack <= 1'b1;
                r_state   <= S_ISSUE;
              end else begin
                r_fp    <= r_fp + FP_ONE;
                r_state <= S_OPC;
              end
`else
              r_fp    <= r_fp + FP_ONE;
              r_state <= S_OPC;
`endif
            end else begin
              r_state <= S_HOLD;
            end
          end
          default: begin
            r_valid <= 1'b0;
            r_state <= S_ISSUE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: ROM model plus an instruction-stream
// reference model (address -> opcode/operand/next address).
module tb_rom_fetch_unit;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic       INSTR_VALID;
  logic       INSTR_READY;
  logic [7:0] OPCODE;
  logic [7:0] OPERAND;
  logic       HAS_OPERAND;
  logic [7:0] PC;
  logic       JUMP_EN;
  logic [7:0] JUMP_ADDR;
`ifdef FETCH_IRQ_EN
  logic       IRQ;
  logic       IRQ_ACK;
  logic [7:0] RET_PC;
`endif

  rom_fetch_unit dut (
    .CLK(CLK), .RESETn(RESETn), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .OPCODE(OPCODE),
    .OPERAND(OPERAND), .HAS_OPERAND(HAS_OPERAND), .PC(PC),
    .JUMP_EN(JUMP_EN), .JUMP_ADDR(JUMP_ADDR)
`ifdef FETCH_IRQ_EN
    , .IRQ(IRQ), .IRQ_ACK(IRQ_ACK), .RET_PC(RET_PC)
`endif
  );

  always #5 CLK = ~CLK;

  logic [7:0] rom [256];
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what an instruction starting at address a looks like.
  function automatic logic m_has(input logic [7:0] a);
    logic [7:0] op;
    op = rom[a];
    return op[3];
  endfunction
  function automatic logic [7:0] m_opnd(input logic [7:0] a);
    logic [7:0] b;
    b = a + 8'd1;
    return m_has(a) ? rom[b] : 8'h00;
  endfunction
  function automatic logic [7:0] m_next(input logic [7:0] a);
    return a + 8'd1 + {7'd0, m_has(a)};
  endfunction

  function automatic logic [33:0] snap();
    return {INSTR_VALID, HAS_OPERAND, OPCODE, OPERAND, PC, ROM_ADDR};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_instr(input string tag);
    chk({tag, "_valid"}, INSTR_VALID, 1'b1);
    chk({tag, "_pc"}, PC, m_pc);
    chk({tag, "_opc"}, OPCODE, rom[m_pc]);
    chk({tag, "_opnd"}, OPERAND, m_opnd(m_pc));
    chk({tag, "_has"}, HAS_OPERAND, m_has(m_pc));
  endtask

  task automatic do_reset();
    RESETn = 1'b0; INSTR_READY = 1'b0; JUMP_EN = 1'b0; JUMP_ADDR = 8'h00;
`ifdef FETCH_IRQ_EN
    IRQ = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_state", snap(), {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
    @(negedge CLK);
    RESETn = 1'b1;
    m_pc = 8'h00;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!INSTR_VALID && k < 12) begin
      tick();
      k++;
    end
    chk({tag, "_wait_valid"}, INSTR_VALID, 1'b1);
  endtask

  task automatic handshake();
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
    m_pc = m_next(m_pc);
  endtask

  // Randomised stream: checks every accepted instruction, stall stability,
  // jump squash and (READY always high) the 2/3-cycle cadence.
  task automatic run(input int ncyc, input int rdy_pct, input int jmp_pct);
    logic [33:0] saved;
    logic        was_stall;
    logic        was_jump;
    int          last_hs;
    was_stall = 1'b0; was_jump = 1'b0; last_hs = -1; saved = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (was_stall) chk("stall_hold", snap(), saved);
      if (was_jump)  chk("jump_squash", INSTR_VALID, 1'b0);
      INSTR_READY = (int'($urandom_range(99)) < rdy_pct);
      JUMP_EN     = (int'($urandom_range(99)) < jmp_pct);
      JUMP_ADDR   = 8'($urandom);
      if (INSTR_VALID && INSTR_READY) begin
        check_instr("stream");
        if (last_hs >= 0) chk("cadence", cyc - last_hs, 2 + int'(m_has(m_pc)));
        last_hs = (rdy_pct == 100 && !JUMP_EN) ? cyc : -1;
        m_pc = m_next(m_pc);
      end
      if (JUMP_EN) begin
        m_pc    = JUMP_ADDR;
        last_hs = -1;
      end
      was_stall = INSTR_VALID && !INSTR_READY && !JUMP_EN;
      was_jump  = JUMP_EN;
      saved     = snap();
      tick();
    end
    INSTR_READY = 1'b0;
    JUMP_EN     = 1'b0;
  endtask

  initial begin
    logic [33:0] held;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

    // 1-byte instruction straight out of reset, READY high.
    rom[8'h00] = 8'h12;
    do_reset();
    INSTR_READY = 1'b1;
    tick();
    chk("t1_not_yet", INSTR_VALID, 1'b0);
    tick();
    chk("t1_first_valid", INSTR_VALID, 1'b1);
    chk("t1_opc", OPCODE, 8'h12);
    chk("t1_pc", PC, 8'h00);
    chk("t1_opnd", OPERAND, 8'h00);
    handshake();
    run(40, 100, 0);

    // 2-byte instruction, then stall 5 cycles on the next one.
    rom[8'h00] = 8'h08; rom[8'h01] = 8'h5A;
    do_reset();
    wait_valid("t2");
    chk("t2_opc", OPCODE, 8'h08);
    chk("t2_opnd", OPERAND, 8'h5A);
    chk("t2_has", HAS_OPERAND, 1'b1);
    handshake();
    wait_valid("t2b");
    chk("t2_next_pc", PC, 8'h02);
    check_instr("t2b");
    held = snap();
    repeat (5) begin
      tick();
      chk("t3_stall", snap(), held);
    end
    handshake();
    run(20, 100, 0);

    // Jump while the operand byte is in flight.
    do_reset();
    tick();
    tick();
    chk("t4_in_arg_addr", ROM_ADDR, 8'h02);
    JUMP_EN = 1'b1; JUMP_ADDR = 8'h40;
    tick();
    JUMP_EN = 1'b0;
    chk("t4_squash", INSTR_VALID, 1'b0);
    m_pc = 8'h40;
    wait_valid("t4");
    chk("t4_pc", PC, 8'h40);
    check_instr("t4");

    // Operand wraps from FF to 00.
    rom[8'hFF] = 8'h08; rom[8'h00] = 8'h77;
    do_reset();
    tick();
    JUMP_EN = 1'b1; JUMP_ADDR = 8'hFF;
    tick();
    JUMP_EN = 1'b0;
    m_pc = 8'hFF;
    wait_valid("t5");
    chk("t5_opc", OPCODE, 8'h08);
    chk("t5_opnd", OPERAND, 8'h77);
    chk("t5_pc", PC, 8'hFF);
    handshake();
    wait_valid("t5b");
    chk("t5_next_pc", PC, 8'h01);
    check_instr("t5b");

    // Random program with back-pressure and jumps.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset();
    run(400, 70, 5);

    // Asynchronous reset in the middle of fetches.
    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(3, 9)), 100, 0);
      #2;
      RESETn = 1'b0;
      #1;
      chk("midrst_state", snap(), {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
      @(negedge CLK);
      RESETn = 1'b1;
      m_pc = 8'h00;
      run(30, 80, 0);
    end

`ifdef FETCH_IRQ_EN
    rom[8'h10] = 8'h12;
    do_reset();
    tick();
    JUMP_EN = 1'b1; JUMP_ADDR = 8'h10;
    tick();
    JUMP_EN = 1'b0;
    m_pc = 8'h10;
    wait_valid("irq");
    IRQ = 1'b1; INSTR_READY = 1'b1;
    tick();
    IRQ = 1'b0; INSTR_READY = 1'b0;
    chk("irq_ack", IRQ_ACK, 1'b1);
    chk("irq_ret_pc", RET_PC, 8'h11);
    tick();
    chk("irq_ack_pulse", IRQ_ACK, 1'b0);
    m_pc = 8'hF0;
    wait_valid("irq_vec");
    chk("irq_vec_pc", PC, 8'hF0);
    IRQ = 1'b1; JUMP_EN = 1'b1; JUMP_ADDR = 8'h20; INSTR_READY = 1'b1;
    tick();
    IRQ = 1'b0; JUMP_EN = 1'b0; INSTR_READY = 1'b0;
    chk("irq_vs_jump_ack", IRQ_ACK, 1'b0);
    m_pc = 8'h20;
    wait_valid("irq_jump");
    chk("irq_jump_pc", PC, 8'h20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
